// File: rtl/usb_pkg.sv
// Shared types and sizing for the USB endpoint data buffer.
package usb_pkg;

  localparam int USB_BUF_DEPTH = 64;
  localparam int USB_OCC_W     = $clog2(USB_BUF_DEPTH) + 1;

  typedef logic [7:0] usb_byte_t;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_RX,
    WR_AHB
  } buf_wr_sel_t;

endpackage

// File: rtl/usb_buf_ptr.sv
// Wrapping FIFO pointer: sync active-low reset, clear, increment (wraps naturally).
module usb_buf_ptr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!n_rst)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/usb_data_buffer.sv
// Byte-wide circular FIFO between USB RX/AHB writers and AHB/TX readers.
// Optional almost_full output enabled by defining USB_BUF_WATERMARK_EN.
module usb_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH = USB_BUF_DEPTH,
  parameter int OCC_W = $clog2(DEPTH) + 1
`ifdef USB_BUF_WATERMARK_EN
  , parameter int WATERMARK = 56
`endif
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             store_tx_data,
  input  logic [7:0]       tx_data,
  input  logic             get_rx_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       buffer_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             buf_overflow,
  output logic             buf_underflow,
  output logic             buf_collision
`ifdef USB_BUF_WATERMARK_EN
  , output logic           almost_full
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  usb_byte_t        r_mem [DEPTH];
  logic [OCC_W-1:0] r_occ;
  logic [PTR_W-1:0] w_wptr, w_rptr;
  buf_wr_sel_t      w_wr_sel;
  usb_byte_t        w_wr_byte;
  logic             w_push_req, w_pop_req, w_full, w_empty;
  logic             w_push_ok, w_pop_ok;
  logic [OCC_W-1:0] w_occ_next;

  always_comb begin
    w_wr_sel = WR_NONE;
    if (store_rx_packet_data) w_wr_sel = WR_RX;
    else if (store_tx_data)   w_wr_sel = WR_AHB;
  end

  always_comb begin
    w_wr_byte = rx_packet_data;
    if (w_wr_sel == WR_AHB) w_wr_byte = tx_data;
  end

  assign w_push_req = (w_wr_sel != WR_NONE);
  assign w_pop_req  = get_rx_data | get_tx_packet_data;
  assign w_full     = (r_occ == OCC_W'(DEPTH));
  assign w_empty    = (r_occ == '0);
  // A pop frees a slot in the same cycle, so a push into a full buffer is legal then.
  assign w_pop_ok   = w_pop_req & ~w_empty;
  assign w_push_ok  = w_push_req & (~w_full | w_pop_ok);
  assign w_occ_next = r_occ + OCC_W'(w_push_ok) - OCC_W'(w_pop_ok);

  assign buffer_data      = w_empty ? 8'h00 : r_mem[w_rptr];
  assign buffer_occupancy = r_occ;

  usb_buf_ptr #(.W(PTR_W)) u_wptr (
    .clk(clk), .n_rst(n_rst), .clr(flush), .inc(w_push_ok), .ptr(w_wptr)
  );

  usb_buf_ptr #(.W(PTR_W)) u_rptr (
    .clk(clk), .n_rst(n_rst), .clr(flush), .inc(w_pop_ok), .ptr(w_rptr)
  );

  always_ff @(posedge clk) begin
    if (n_rst && !flush && w_push_ok) r_mem[w_wptr] <= w_wr_byte;
  end

  always_ff @(posedge clk) begin
    if (!n_rst || flush) begin
      r_occ         <= '0;
      buf_overflow  <= 1'b0;
      buf_underflow <= 1'b0;
      buf_collision <= 1'b0;
    end else begin
      r_occ <= w_occ_next;
      if (w_push_req && !w_push_ok) buf_overflow  <= 1'b1;
      if (w_pop_req && w_empty)     buf_underflow <= 1'b1;
      if ((store_rx_packet_data && store_tx_data) ||
          (get_rx_data && get_tx_packet_data))
        buf_collision <= 1'b1;
    end
  end

`ifdef USB_BUF_WATERMARK_EN
  always_ff @(posedge clk) begin
    if (!n_rst || flush) almost_full <= 1'b0;
    else                 almost_full <= (w_occ_next >= OCC_W'(WATERMARK));
  end
`endif

endmodule

// File: doc/usb_data_buffer.md
Name: usb_data_buffer

Overview:
- Byte-wide circular FIFO between the receive block and the AHB-Lite slave / transmit block of the USB endpoint.
- Absorbs packet payload bytes from the RX side (store_rx_packet_data/rx_packet_data) and from AHB writes.
- Serves reads to the AHB side (RX payload) and to the TX encoder.
- Reports buffer_occupancy, which the RX block uses to detect payload overflow; RX flush clears it.

Parameters:
DEPTH, 64, number of byte entries; power of two, 4..64
OCC_W, $clog2(DEPTH)+1, width of buffer_occupancy (7 at default)

Ports:
clk  in  1  system clock
n_rst  in  1  synchronous active-low reset, sampled on rising clk
flush  in  1  from RX / AHB; empties buffer
store_rx_packet_data  in  1  RX write strobe, one byte per cycle
rx_packet_data  in  8  RX write byte
store_tx_data  in  1  AHB write strobe
tx_data  in  8  AHB write byte
get_rx_data  in  1  AHB read/pop strobe
get_tx_packet_data  in  1  TX read/pop strobe
buffer_data  out  8  head byte (first-word-fall-through)
buffer_occupancy  out  OCC_W  bytes held, 0..DEPTH
buf_overflow  out  1  sticky: write attempted while full
buf_underflow  out  1  sticky: pop attempted while empty
buf_collision  out  1  sticky: two writers or two readers in same cycle

Behaviour:
- Single clock domain; all state changes on rising clk.
- Reset: n_rst low at a rising edge clears wptr, rptr, occupancy, buf_overflow, buf_underflow and buf_collision. Memory contents are not reset.
- Reset mid-operation discards all data.
- State: wptr, rptr (log2(DEPTH) bits, natural wrap DEPTH-1 -> 0), occ (OCC_W bits).
- Full = (occ == DEPTH); empty = (occ == 0).
- buffer_data is combinational:
  - mem[rptr] when occ != 0
  - 8'h00 when empty
- Write select:
  - RX has priority over AHB.
  - Both strobes asserted: RX byte written, AHB byte dropped, buf_collision set.
- Read select:
  - Either strobe pops one byte.
  - Both strobes asserted: exactly one pop, buf_collision set.
- Push when not full: mem[wptr] <= byte; wptr+1.
- Push when full:
  - Ignored, buf_overflow set, no state change.
  - Exception: a pop in the same cycle makes the push legal; occ stays DEPTH.
- Pop when not empty: rptr+1.
- Pop when empty:
  - Ignored, buf_underflow set.
  - A same-cycle push is not forwarded; the push completes and occ becomes 1.
- Simultaneous legal push and pop: occ unchanged, both pointers advance.
- Occupancy: occ + push_ok - pop_ok, never below 0 or above DEPTH.
- buffer_occupancy = occ, registered; it reflects the current cycle's operations on the next cycle.
- flush:
  - Highest priority after reset.
  - Sets wptr = rptr = 0 and occ = 0.
  - Clears all three sticky flags.
  - Any push/pop in the same cycle is ignored.
- Sticky flags clear only by reset or flush.
- No latency beyond one cycle: a byte pushed at edge N is visible on buffer_data after edge N if the buffer was empty.

Optional Feature:
- Macro: USB_BUF_WATERMARK_EN.
- Defined:
  - Adds parameter WATERMARK (default 56) and output almost_full (1 bit, registered).
  - almost_full is high when next occ >= WATERMARK; reset/flush value 0.
  - RX uses it to NAK early.
- Undefined: the port and parameter do not exist; no logic is generated.

Decomposition:
- usb_pkg:
  - USB_BUF_DEPTH = 64
  - USB_OCC_W
  - typedef logic [7:0] usb_byte_t
  - typedef enum {WR_NONE, WR_RX, WR_AHB} buf_wr_sel_t
- Sub-module usb_buf_ptr:
  - Wrapping pointer register with sync active-low reset, clear and increment.
  - Instantiated twice (wptr, rptr).
- Storage is an inferred register array inside usb_data_buffer.

Test Plan:
- Reset: n_rst=0 for 2 cycles with both strobes high -> occupancy 0, buffer_data 8'h00, all flags 0.
- RX stores 8'hA5, 8'h3C, 8'h7E on consecutive cycles -> occupancy 1,2,3. get_rx_data x3 -> buffer_data A5, 3C, 7E, then 00; occupancy 0.
- Fill with 64 bytes 0..63, then one more store 8'hFF -> occupancy 64, buf_overflow=1. Pops return 0..63 in order, wrapping correctly across index 63->0.
- Full buffer with simultaneous store 8'h40 and pop -> occupancy stays 64, no overflow. Popped byte is 0; last entry becomes 8'h40.
- store_rx_packet_data and store_tx_data together (8'h11 / 8'h22) -> only 8'h11 stored, occupancy +1, buf_collision=1. get_rx_data and get_tx_packet_data together -> single pop, occupancy -1.
- Pop on empty -> buf_underflow=1. Then flush with occupancy 10 plus a concurrent store -> occupancy 0 next cycle, flags cleared, stored byte discarded.
